// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate sweep block: FSM state encoding
// and the width of the per-vector hold counter.
package logic_gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/gate_core.sv
// Purely combinational N-input reductions (AND/OR/XOR and their inversions)
// of one operand vector.
module gate_core #(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  output logic            and_r,
  output logic            or_r,
  output logic            xor_r,
  output logic            nand_r,
  output logic            nor_r,
  output logic            xnor_r
);

  assign and_r  = &vec;
  assign or_r   = |vec;
  assign xor_r  = ^vec;
  assign nand_r = ~&vec;
  assign nor_r  = ~|vec;
  assign xnor_r = ~^vec;

endmodule

// File: rtl/logic_gate_sweep.sv
// Gate sweep top: follows ext_x in IDLE, or walks every N_IN-bit vector on request.
// Optional self-checker enabled by defining LOGIC_SWEEP_CHECK_EN.
module logic_gate_sweep
  import logic_gate_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_IN-1:0] ext_x,
  output logic [N_IN-1:0] vec_o,
  output logic            and_o,
  output logic            or_o,
  output logic            xor_o,
  output logic            nand_o,
  output logic            nor_o,
  output logic            xnor_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam logic [N_IN:0]       LAST_VEC = {1'b0, {N_IN{1'b1}}};
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_CYC - 1);

  state_t              state, state_nxt;
  logic [N_IN:0]       vec_cnt, cnt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [N_IN-1:0]     vec_nxt;
  logic                valid_nxt;
  logic                g_and, g_or, g_xor, g_nand, g_nor, g_xnor;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = vec_cnt;
    hold_nxt  = hold_cnt;
    vec_nxt   = vec_o;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
          hold_nxt  = '0;
          vec_nxt   = '0;
          valid_nxt = 1'b1;
        end else begin
          vec_nxt   = ext_x;
        end
      end
      SWEEP: begin
        if (hold_cnt == HOLD_MAX) begin
          hold_nxt = '0;
          // The counter stops at the last vector instead of wrapping.
          if (vec_cnt == LAST_VEC) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = vec_cnt + (N_IN+1)'(1);
            vec_nxt   = cnt_nxt[N_IN-1:0];
            valid_nxt = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        vec_nxt   = ext_x;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // Reductions are taken from the next vector so they register alongside it.
  gate_core #(.N_IN(N_IN)) u_core (
    .vec    (vec_nxt),
    .and_r  (g_and),
    .or_r   (g_or),
    .xor_r  (g_xor),
    .nand_r (g_nand),
    .nor_r  (g_nor),
    .xnor_r (g_xnor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_cnt  <= '0;
      hold_cnt <= '0;
      vec_o    <= '0;
      and_o    <= 1'b0;
      or_o     <= 1'b0;
      xor_o    <= 1'b0;
      nand_o   <= 1'b0;
      nor_o    <= 1'b0;
      xnor_o   <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      vec_cnt  <= cnt_nxt;
      hold_cnt <= hold_nxt;
      vec_o    <= vec_nxt;
      and_o    <= g_and;
      or_o     <= g_or;
      xor_o    <= g_xor;
      nand_o   <= g_nand;
      nor_o    <= g_nor;
      xnor_o   <= g_xnor;
      valid_o  <= valid_nxt;
      busy_o   <= (state_nxt == SWEEP);
      done_o   <= (state_nxt == DONE);
    end
  end

`ifdef LOGIC_SWEEP_CHECK_EN
  logic [3:0] ones;
  logic       chk_and, chk_or, chk_xor, mismatch;

  // Independent reference: derive every reduction from a population count.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_IN; i++) begin
      ones = ones + {3'b000, vec_o[i]};
    end
    chk_and  = (ones == 4'(N_IN));
    chk_or   = (ones != 4'd0);
    chk_xor  = ones[0];
    mismatch = (and_o  != chk_and)  | (or_o  != chk_or)  | (xor_o  != chk_xor) |
               (nand_o != !chk_and) | (nor_o != !chk_or) | (xnor_o != !chk_xor);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (state == IDLE && start) begin
      err_o <= 1'b0;
    end else if (state == SWEEP && mismatch) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
